vga_text_pixel_pipe: RTL

VGA_TEXT_PIXEL_PIPE -- requirements
Module: vga_text_pixel_pipe

---
 rtl/vga_text_pixel_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/vga_text_pixel_pipe.sv
// Text-mode pixel pipeline: glyph/attribute in, charset ROM lookup, coloured pixel out after ROM_LAT+1 cycles.
// Cursor hit-test and blink counter are built only when VGA_TEXT_CURSOR_EN is defined.
module vga_text_pixel_pipe #(
    parameter int COLOR_W      = 8,
    parameter int CHAR_W       = 8,
    parameter int CHAR_H       = 8,
    parameter int ROM_LAT      = 1,
    parameter int BLINK_FRAMES = 30
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        bright,
    input  logic                        hsync_in,
    input  logic                        vsync_in,
    input  logic                        frame_start,
    input  logic [9:0]                  x,
    input  logic [8:0]                  y,
    input  logic [15:0]                 glyph,
    input  logic                        cursor_on,
    input  logic [6:0]                  cursor_col,
    input  logic [5:0]                  cursor_row,
    output logic [8+$clog2(CHAR_H)-1:0] rom_addr,
    input  logic [CHAR_W-1:0]           rom_data,
    output logic [COLOR_W-1:0]          r,
    output logic [COLOR_W-1:0]          g,
    output logic [COLOR_W-1:0]          b,
    output logic                        hsync_out,
    output logic                        vsync_out,
    output logic                        bright_out
);
    localparam int COL_BITS = $clog2(CHAR_W);
    localparam int ROW_BITS = $clog2(CHAR_H);
    // Sideband word: {bright, hsync, vsync, cursor_hit, attr[7:0], col}
    localparam int SB_W = 12 + COL_BITS;
    localparam logic [SB_W-1:0] SB_RST = {4'b0110, {(8 + COL_BITS){1'b0}}};

    function automatic logic [COLOR_W-1:0] expand2(input logic [1:0] v);
        logic [COLOR_W-1:0] e;
        for (int i = 0; i < COLOR_W; i++) begin
            e[i] = (((COLOR_W - 1 - i) % 2) == 0) ? v[1] : v[0];
        end
        return e;
    endfunction

    assign rom_addr = {glyph[7:0], y[ROW_BITS-1:0]};

    logic cursor_hit;
    logic blink_on;

`ifdef VGA_TEXT_CURSOR_EN
    logic [9:0] cell_x;
    logic [8:0] cell_y;
    logic [7:0] blink_cnt_q, blink_cnt_d;
    logic       blink_phase_q, blink_phase_d;

    assign cell_x     = x >> COL_BITS;
    assign cell_y     = y >> ROW_BITS;
    assign cursor_hit = cursor_on && (cell_x == {3'b000, cursor_col})
                                  && (cell_y == {3'b000, cursor_row});
    assign blink_on   = blink_phase_q;

    always_comb begin
        blink_cnt_d   = blink_cnt_q;
        blink_phase_d = blink_phase_q;
        if (frame_start) begin
            if (blink_cnt_q == 8'(BLINK_FRAMES - 1)) begin
                blink_cnt_d   = 8'd0;
                blink_phase_d = ~blink_phase_q;
            end else begin
                blink_cnt_d = blink_cnt_q + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            blink_cnt_q   <= 8'd0;
            blink_phase_q <= 1'b1;
        end else begin
            blink_cnt_q   <= blink_cnt_d;
            blink_phase_q <= blink_phase_d;
        end
    end
`else
    logic unused_cursor;
    assign unused_cursor = ^{frame_start, cursor_on, cursor_col, cursor_row,
                             x[9:COL_BITS], y[8:ROW_BITS]};
    assign cursor_hit    = 1'b0;
    assign blink_on      = 1'b0;
`endif

    logic [SB_W-1:0] sb_d [ROM_LAT];
    logic [SB_W-1:0] sb_q [ROM_LAT];

    generate
        for (genvar gi = 0; gi < ROM_LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign sb_d[gi] = {bright, hsync_in, vsync_in, cursor_hit,
                                   glyph[15:8], x[COL_BITS-1:0]};
            end else begin : g_tail
                assign sb_d[gi] = sb_q[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ROM_LAT; i++) sb_q[i] <= SB_RST;
        end else begin
            for (int i = 0; i < ROM_LAT; i++) sb_q[i] <= sb_d[i];
        end
    end

    logic                dly_bright, dly_hs, dly_vs, dly_hit;
    logic [7:0]          dly_attr;
    logic [COL_BITS-1:0] dly_col;
    assign {dly_bright, dly_hs, dly_vs, dly_hit, dly_attr, dly_col} = sb_q[ROM_LAT-1];

    // Bit-reverse the ROM row so the column index selects directly (MSB is leftmost pixel).
    logic [CHAR_W-1:0] rom_rev;
    generate
        for (genvar gi = 0; gi < CHAR_W; gi++) begin : g_rev
            assign rom_rev[gi] = rom_data[CHAR_W-1-gi];
        end
    endgenerate

    logic               draw;
    logic [COLOR_W-1:0] r_d, g_d, b_d, r_q, g_q, b_q;
    logic               hsync_q, vsync_q, bright_q;

    always_comb begin
        draw = rom_rev[dly_col] ^ (dly_hit & blink_on);
        r_d  = '0;
        g_d  = '0;
        b_d  = '0;
        if (dly_bright) begin
            if (draw) begin
                r_d = expand2(dly_attr[5:4]);
                g_d = expand2(dly_attr[3:2]);
                b_d = expand2(dly_attr[1:0]);
            end else begin
                r_d = expand2(dly_attr[7:6]);
                g_d = expand2(dly_attr[7:6]);
                b_d = expand2(dly_attr[7:6]);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q      <= '0;
            g_q      <= '0;
            b_q      <= '0;
            hsync_q  <= 1'b1;
            vsync_q  <= 1'b1;
            bright_q <= 1'b0;
        end else begin
            r_q      <= r_d;
            g_q      <= g_d;
            b_q      <= b_d;
            hsync_q  <= dly_hs;
            vsync_q  <= dly_vs;
            bright_q <= dly_bright;
        end
    end

    assign r          = r_q;
    assign g          = g_q;
    assign b          = b_q;
    assign hsync_out  = hsync_q;
    assign vsync_out  = vsync_q;
    assign bright_out = bright_q;
endmodule
